hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core. Generates every stall and flush strobe for the PC, IF/ID, ID/EX and EX/MEM registers from decode/execute/memory-stage status, and sequences the two multi-cycle events: iterative divide (fixed-length stall) and trap/mret entry (flush plus redirect plus drain). It sits beside the datapath. Its outputs drive the `*_stall`/`*_flush` inputs of the pipeline registers and the PC-source mux.

---
 rtl/hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central pipeline sequencer for the 5-stage core. Produces every stall and
//   flush strobe for the PC, IF/ID, ID/EX and EX/MEM registers, selects the PC
//   source on trap/mret, and sequences the two multi-cycle events: a fixed-length
//   iterative divide stall and the trap/mret flush-plus-drain.
//
//   Parameters
//     DIV_CYCLES  total cycles the divider occupies EX, counted from the start
//                 cycle (2..255)
//     CNT_W       width of the stall-cycle performance counter
//
//   Ports
//     i_clk, i_rst             clock, asynchronous active-high reset
//     i_clk_en                 global step enable for all registered state
//     i_rs1_d, i_rs2_d         ID-stage source registers
//     i_rd_e, i_mem_read_e     EX-stage destination / load flag
//     i_branch_taken_e         EX resolved a taken branch/jump
//     i_div_start_e            EX holds a div/rem (first cycle)
//     i_exception_valid_m      exception committed in MEM
//     i_mret_m                 mret in MEM
//     o_*_stall / o_*_flush    pipeline register controls
//     o_pc_sel                 00 seq/branch, 01 trap vector, 10 mepc
//     o_div_busy               divider sequence active
//     o_stall_cycles           saturating count of cycles with o_pc_stall=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [4:0]       i_rs1_d,
    input  logic [4:0]       i_rs2_d,
    input  logic [4:0]       i_rd_e,
    input  logic             i_mem_read_e,
    input  logic             i_branch_taken_e,
    input  logic             i_div_start_e,
    input  logic             i_exception_valid_m,
    input  logic             i_mret_m,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_if_id_flush_exception,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_flush,
    output logic [1:0]       o_pc_sel,
    output logic             o_div_busy,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIV   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_TRAP = 2'b01;
    localparam logic [1:0] PC_MEPC = 2'b10;

    state_t           state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic             div_done_q, div_done_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic trap_any;
    logic load_use;
    logic div_enter;

    assign trap_any = i_exception_valid_m | i_mret_m;
    assign load_use = i_mem_read_e && (i_rd_e != 5'd0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
    // The cycle after a divide completes the same instruction is still leaving
    // EX with i_div_start_e high; div_done_q keeps it from restarting.
    assign div_enter = (state_q == ST_RUN) && !i_branch_taken_e &&
                       i_div_start_e && !div_done_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours regardless of process evaluation order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            div_cnt_q   <= '0;
            div_done_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_done_q  <= div_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        div_done_d  = div_done_q;
        stall_cnt_d = stall_cnt_q;

        if (i_clk_en) begin
            div_done_d = 1'b0;
            if (o_pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end

            if (trap_any) begin
                // Trap/mret aborts any divide in flight.
                state_d   = ST_DRAIN;
                div_cnt_d = '0;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (div_enter) begin
                            // Start cycle counts as one busy cycle, and the
                            // terminal count-0 cycle as another.
                            state_d   = ST_DIV;
                            div_cnt_d = 8'(DIV_CYCLES - 2);
                        end
                    end
                    ST_DIV: begin
                        if (div_cnt_q == 8'd0) begin
                            state_d    = ST_RUN;
                            div_done_d = 1'b1;
                        end else begin
                            div_cnt_d = div_cnt_q - 8'd1;
                        end
                    end
                    ST_DRAIN: state_d = ST_RUN;
                    default:  state_d = ST_RUN;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic (combinational from state and current inputs)
    // -------------------------------------------------------------------------
    always_comb begin
        o_pc_stall              = 1'b0;
        o_if_id_stall           = 1'b0;
        o_if_id_flush           = 1'b0;
        o_if_id_flush_exception = 1'b0;
        o_id_ex_stall           = 1'b0;
        o_id_ex_flush           = 1'b0;
        o_ex_mem_flush          = 1'b0;
        o_pc_sel                = PC_SEQ;
        o_div_busy              = 1'b0;

        if (i_exception_valid_m) begin
            o_if_id_flush_exception = 1'b1;
            o_id_ex_flush           = 1'b1;
            o_ex_mem_flush          = 1'b1;
            o_pc_sel                = PC_TRAP;
        end else if (i_mret_m) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            o_pc_sel       = PC_MEPC;
        end else begin
            unique case (state_q)
                ST_DRAIN: begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end
                ST_DIV: begin
                    o_pc_stall     = 1'b1;
                    o_if_id_stall  = 1'b1;
                    o_id_ex_stall  = 1'b1;
                    o_ex_mem_flush = 1'b1;
                    o_div_busy     = 1'b1;
                end
                default: begin
                    if (i_branch_taken_e) begin
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (div_enter) begin
                        o_pc_stall     = 1'b1;
                        o_if_id_stall  = 1'b1;
                        o_id_ex_stall  = 1'b1;
                        o_ex_mem_flush = 1'b1;
                        o_div_busy     = 1'b1;
                    end else if (load_use) begin
                        // ID/EX gets a bubble while the load completes.
                        o_pc_stall    = 1'b1;
                        o_if_id_stall = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed-vector bench for hazard_ctrl (DIV_CYCLES=4, CNT_W=4 so the perf
//   counter saturates quickly). The stimulus process applies one vector per
//   cycle and pushes its hand-computed expected outputs into a queue; a monitor
//   pops one entry each falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int DIV_CYCLES = 4;
    localparam int CNT_W      = 4;

    // Flag bits: {pc_stall, if_id_stall, if_id_flush, if_id_flush_exc,
    //             id_ex_stall, id_ex_flush, ex_mem_flush}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0010010;
    localparam logic [6:0] DR   = 7'b0010010;
    localparam logic [6:0] DV   = 7'b1100101;
    localparam logic [6:0] TR   = 7'b0001011;
    localparam logic [6:0] MR   = 7'b0010011;

    typedef struct packed {
        logic [6:0]       f;
        logic [1:0]       sel;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } out_t;

    typedef struct {
        int   id;
        out_t e;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_en = 1'b1;
    logic [4:0]       rs1 = '0, rs2 = '0, rd = '0;
    logic             mem_read = 1'b0, branch = 1'b0, div_start = 1'b0;
    logic             exc = 1'b0, mret = 1'b0;

    logic             pc_stall, if_id_stall, if_id_flush, if_id_flush_exc;
    logic             id_ex_stall, id_ex_flush, ex_mem_flush, div_busy;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] stall_cycles;

    sb_t sb[$];
    int  vec_id     = 0;
    int  applied    = 0;
    int  miscompares = 0;

    hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_clk_en               (clk_en),
        .i_rs1_d                (rs1),
        .i_rs2_d                (rs2),
        .i_rd_e                 (rd),
        .i_mem_read_e           (mem_read),
        .i_branch_taken_e       (branch),
        .i_div_start_e          (div_start),
        .i_exception_valid_m    (exc),
        .i_mret_m               (mret),
        .o_pc_stall             (pc_stall),
        .o_if_id_stall          (if_id_stall),
        .o_if_id_flush          (if_id_flush),
        .o_if_id_flush_exception(if_id_flush_exc),
        .o_id_ex_stall          (id_ex_stall),
        .o_id_ex_flush          (id_ex_flush),
        .o_ex_mem_flush         (ex_mem_flush),
        .o_pc_sel               (pc_sel),
        .o_div_busy             (div_busy),
        .o_stall_cycles         (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic out_t ex(input logic [6:0] f, input logic [1:0] sel,
                                input logic busy, input int cnt);
        out_t o;
        o.f    = f;
        o.sel  = sel;
        o.busy = busy;
        o.cnt  = CNT_W'(cnt);
        return o;
    endfunction

    // One vector: inputs driven just after the rising edge, expectation queued.
    task automatic vec(input logic r, input logic en,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic mr, input logic br, input logic ds,
                       input logic ev, input logic mt, input out_t e);
        sb_t item;
        @(posedge clk);
        #1;
        rst = r; clk_en = en; rs1 = s1; rs2 = s2; rd = d;
        mem_read = mr; branch = br; div_start = ds; exc = ev; mret = mt;
        vec_id++;
        item.id = vec_id;
        item.e  = e;
        sb.push_back(item);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    initial begin
        sb_t  item;
        out_t act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                item = sb.pop_front();
                act.f    = {pc_stall, if_id_stall, if_id_flush, if_id_flush_exc,
                            id_ex_stall, id_ex_flush, ex_mem_flush};
                act.sel  = pc_sel;
                act.busy = div_busy;
                act.cnt  = stall_cycles;
                applied++;
                if (act !== item.e) begin
                    miscompares++;
                    $display("FAIL vec%0d: got flags=%b sel=%b busy=%b cnt=%0d, expected flags=%b sel=%b busy=%b cnt=%0d",
                             item.id, act.f, act.sel, act.busy, act.cnt,
                             item.e.f, item.e.sel, item.e.busy, item.e.cnt);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        //      rst en rs1 rs2 rd  mr br ds ex mt  expected
        // Reset state, then idle after release.
        vec(1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 0));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 0));
        // Load-use on rs2, then gone; rd=0 never stalls; load-use on rs1.
        vec(0, 1, 0, 5, 5,  1, 0, 0, 0, 0,  ex(LU,   2'b00, 0, 0));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 1));
        vec(0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 1));
        vec(0, 1, 7, 0, 7,  1, 0, 0, 0, 0,  ex(LU,   2'b00, 0, 1));
        vec(0, 1, 7, 0, 7,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 2));
        // Divide with div_start held: exactly 4 busy cycles, no re-entry after.
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(DV,   2'b00, 1, 2));
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(DV,   2'b00, 1, 3));
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(DV,   2'b00, 1, 4));
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(DV,   2'b00, 1, 5));
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(NONE, 2'b00, 0, 6));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 6));
        // Trap on DIV cycle 2, drain, back to RUN.
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(DV,   2'b00, 1, 6));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 1, 0,  ex(TR,   2'b01, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(DR,   2'b00, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 7));
        // Branch beats load-use and divide start.
        vec(0, 1, 3, 0, 3,  1, 1, 0, 0, 0,  ex(BR,   2'b00, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 1, 1, 0, 0,  ex(BR,   2'b00, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 7));
        // Mret with clk_en low: strobes shown, state frozen in RUN.
        vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  ex(MR,   2'b10, 0, 7));
        vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  ex(MR,   2'b10, 0, 7));
        vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  ex(MR,   2'b10, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 1,  ex(MR,   2'b10, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(DR,   2'b00, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 7));
        // Perf counter frozen while clk_en is low.
        vec(0, 0, 9, 0, 9,  1, 0, 0, 0, 0,  ex(LU,   2'b00, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 7));
        // Exception beats mret; mret seen in DRAIN re-enters DRAIN.
        vec(0, 1, 0, 0, 0,  0, 0, 0, 1, 1,  ex(TR,   2'b01, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 1,  ex(MR,   2'b10, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(DR,   2'b00, 0, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 7));
        // Async reset between edges during DIV, then a full sequence.
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(DV,   2'b00, 1, 7));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(DV,   2'b00, 1, 8));
        vec(1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 0));
        vec(1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 0));
        vec(0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  ex(DV,   2'b00, 1, 0));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(DV,   2'b00, 1, 1));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(DV,   2'b00, 1, 2));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(DV,   2'b00, 1, 3));
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 4));
        // Sustained load-use drives the perf counter into saturation.
        for (int k = 0; k < 12; k++) begin
            vec(0, 1, 0, 4, 4,  1, 0, 0, 0, 0,  ex(LU, 2'b00, 0, (4 + k > 15) ? 15 : 4 + k));
        end
        vec(0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  ex(NONE, 2'b00, 0, 15));

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            miscompares += sb.size();
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
